kernel_cnn_win_acc: RTL

- Downstream consumer of the 13x6 unsigned product stage in the CNN kernel datapath.
- Accumulates a fixed-length window of unsigned products (one convolution window, e.g. 5x5 = 25 taps) into one partial sum per output pixel.
- Uses a valid/ready handshake on both sides. The result is held until the next stage takes it.

---
 rtl/kernel_cnn_win_acc.sv | 97 +++++++++
 1 files changed

// File: rtl/kernel_cnn_win_acc.sv
// Window accumulator: sums COUNT unsigned products per output pixel and holds
// the result (with a sticky wrap flag) behind a valid/ready handshake.
module kernel_cnn_win_acc #(
  parameter int PROD_WIDTH = 19,
  parameter int ACC_WIDTH  = 32,
  parameter int COUNT      = 25,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  clr,
  input  logic [PROD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  out_ovf,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(COUNT - 1);

  logic [ACC_WIDTH-1:0] acc_r, acc_nxt_s, base_acc_s;
  logic [CNT_WIDTH-1:0] cnt_r, cnt_nxt_s, base_cnt_s;
  logic                 ovf_acc_r, ovf_acc_nxt_s, base_ovf_s;
  logic [ACC_WIDTH-1:0] out_data_r, out_data_nxt_s;
  logic                 out_ovf_r, out_ovf_nxt_s;
  logic                 out_valid_r, out_valid_nxt_s;
  logic                 in_ready_s, beat_s;
  logic [ACC_WIDTH:0]   sum_s;

  assign in_ready_s = ~out_valid_r | out_ready;
  assign beat_s     = in_valid & in_ready_s;

  // Next-state: clr rebases the window to empty before a same-cycle beat is added.
  always_comb begin
    base_acc_s      = clr ? '0   : acc_r;
    base_cnt_s      = clr ? '0   : cnt_r;
    base_ovf_s      = clr ? 1'b0 : ovf_acc_r;
    sum_s           = {1'b0, base_acc_s} + {{(ACC_WIDTH + 1 - PROD_WIDTH){1'b0}}, in_data};
    acc_nxt_s       = base_acc_s;
    cnt_nxt_s       = base_cnt_s;
    ovf_acc_nxt_s   = base_ovf_s;
    out_data_nxt_s  = out_data_r;
    out_ovf_nxt_s   = out_ovf_r;
    out_valid_nxt_s = out_valid_r;
    if (out_valid_r && out_ready) begin
      out_valid_nxt_s = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
    if (beat_s) begin
      if (base_cnt_s == LAST_CNT) begin
        // Last beat: publish the sum and start an empty window next cycle.
        out_data_nxt_s  = sum_s[ACC_WIDTH-1:0];
        out_ovf_nxt_s   = base_ovf_s | sum_s[ACC_WIDTH];
        out_valid_nxt_s = 1'b1;
        acc_nxt_s       = '0;
        cnt_nxt_s       = '0;
        ovf_acc_nxt_s   = 1'b0;
      end else begin
        acc_nxt_s     = sum_s[ACC_WIDTH-1:0];
        cnt_nxt_s     = base_cnt_s + {{(CNT_WIDTH - 1){1'b0}}, 1'b1};
        ovf_acc_nxt_s = base_ovf_s | sum_s[ACC_WIDTH];
      end
    end else begin
      acc_nxt_s = base_acc_s;
    end
  end

  // State and result registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_r       <= '0;
      cnt_r       <= '0;
      ovf_acc_r   <= 1'b0;
      out_data_r  <= '0;
      out_ovf_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      acc_r       <= acc_nxt_s;
      cnt_r       <= cnt_nxt_s;
      ovf_acc_r   <= ovf_acc_nxt_s;
      out_data_r  <= out_data_nxt_s;
      out_ovf_r   <= out_ovf_nxt_s;
      out_valid_r <= out_valid_nxt_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_ovf   = out_ovf_r;
  assign out_valid = out_valid_r;
  assign busy      = (cnt_r != '0);

endmodule
